// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the 7-segment scan decoder.
//   SEG_GLYPH : active-low [6:0] (g..a) patterns for hex digits 0..F
//   SEG_BLANK : all segments off
//   DIG_IDX_W : width of a digit index
//   scan_state_e : scan FSM states
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int unsigned DIG_IDX_W = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } scan_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg_pattern_decode
// Combinational lookup of an active-low 7-segment pattern.
//   seg_i   : pattern [6:0] = g..a, active-low
//   legal_o : pattern is one of the 16 hex glyphs
//   blank_o : pattern is all segments off
//   hex_o   : hex value of the glyph (0 when not legal)
// -----------------------------------------------------------------------------
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] hex_o
);

    always_comb begin
        legal_o = 1'b0;
        hex_o   = '0;
        blank_o = (seg_i == SEG_BLANK);
        for (int unsigned i = 0; i < 16; i++) begin
            if (seg_i == SEG_GLYPH[i]) begin
                legal_o = 1'b1;
                hex_o   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Snoops a multiplexed common-anode 7-segment bus and recovers each digit.
//   clk, rst_n  : clock, asynchronous active-low reset
//   seg_in      : active-low segments, [7]=DP, [6:0]=g..a
//   dig_en      : digit enables (polarity set by DIG_ACTIVE_LOW)
//   hex_out     : decoded value per digit, digit i at [4i+3:4i]
//   dp_out      : decimal point lit per digit
//   blank       : last capture of the digit was all-off
//   invalid     : last capture of the digit was not a hex glyph
//   upd_pulse   : one-cycle strobe on capture, upd_idx = captured digit
//   frame_valid : one-cycle strobe when every digit has been captured
// -----------------------------------------------------------------------------
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   invalid,
    output logic                    upd_pulse,
    output logic [DIG_IDX_W-1:0]    upd_idx,
    output logic                    frame_valid
);

    // Counter only has to reach STABLE_CYCLES-2 (see capture condition).
    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES - 1) : 1;

    logic [7:0]              seg_s1_q, seg_s2_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   dig_s1_q, dig_s2_q, dig_prev_q;
    logic [NUM_DIGITS-1:0]   sel;
    logic                    onehot, same;
    logic [DIG_IDX_W-1:0]    sel_idx;

    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    capture;

    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d, inv_q, inv_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_next;
    logic                    upd_q, upd_d, frame_q, frame_d;
    logic [DIG_IDX_W-1:0]    idx_q, idx_d;

    logic                    dec_legal, dec_blank;
    logic [3:0]              dec_hex;

    seg_pattern_decode u_decode (
        .seg_i   (seg_s2_q[6:0]),
        .legal_o (dec_legal),
        .blank_o (dec_blank),
        .hex_o   (dec_hex)
    );

    assign sel    = (DIG_ACTIVE_LOW != 0) ? ~dig_s2_q : dig_s2_q;
    assign onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign same   = (seg_s2_q == seg_prev_q) && (dig_s2_q == dig_prev_q);

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) sel_idx = DIG_IDX_W'(i);
        end
    end

    // The edge that first sees a new sample counts as sample #1, so the
    // capture fires on the edge where cnt would reach STABLE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (onehot) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (!same) begin
                    cnt_d   = '0;
                    state_d = onehot ? ST_SETTLE : ST_IDLE;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 2)) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!same) begin
                    cnt_d   = '0;
                    state_d = onehot ? ST_SETTLE : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        hex_d     = hex_q;
        dp_d      = dp_q;
        blank_d   = blank_q;
        inv_d     = inv_q;
        seen_d    = seen_q;
        upd_d     = 1'b0;
        idx_d     = idx_q;
        frame_d   = 1'b0;
        seen_next = seen_q | sel;
        if (capture) begin
            upd_d = 1'b1;
            idx_d = sel_idx;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                    dp_d[i] = ~seg_s2_q[7];
                    if (dec_legal) begin
                        hex_d[4*i +: 4] = dec_hex;
                        inv_d[i]        = 1'b0;
                        blank_d[i]      = 1'b0;
                    end else if (dec_blank) begin
                        inv_d[i]   = 1'b0;
                        blank_d[i] = 1'b1;
                    end else begin
                        inv_d[i]   = 1'b1;
                        blank_d[i] = 1'b0;
                    end
                end
            end
            if (seen_next == '1) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d = seen_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= '0;
            seg_s2_q   <= '0;
            seg_prev_q <= '0;
            dig_s1_q   <= '0;
            dig_s2_q   <= '0;
            dig_prev_q <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hex_q      <= '0;
            dp_q       <= '0;
            blank_q    <= '1;
            inv_q      <= '0;
            seen_q     <= '0;
            upd_q      <= 1'b0;
            idx_q      <= '0;
            frame_q    <= 1'b0;
        end else begin
            seg_s1_q   <= seg_in;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            dig_s1_q   <= dig_en;
            dig_s2_q   <= dig_s1_q;
            dig_prev_q <= dig_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hex_q      <= hex_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            inv_q      <= inv_d;
            seen_q     <= seen_d;
            upd_q      <= upd_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
        end
    end

    assign hex_out     = hex_q;
    assign dp_out      = dp_q;
    assign blank       = blank_q;
    assign invalid     = inv_q;
    assign upd_pulse   = upd_q;
    assign upd_idx     = idx_q;
    assign frame_valid = frame_q;

endmodule
